// File: rtl/anton_neopixel_decoder_pkg.sv
// rtl/anton_neopixel_decoder_pkg.sv - shared states, bit period and clog2 for the neopixel decoder
package anton_neopixel_decoder_pkg;

  // Nominal WS2812 bit period in 7 MHz ticks, shared with the transmitter.
  localparam int BIT_TICKS = 8;

  typedef enum logic [1:0] {
    ENUM_DEC_SYNC = 2'd0,
    ENUM_DEC_IDLE = 2'd1,
    ENUM_DEC_HIGH = 2'd2,
    ENUM_DEC_LOW  = 2'd3
  } dec_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/anton_sync_edge.sv
// rtl/anton_sync_edge.sv - two-flop synchronizer with registered rise/fall pulses
module anton_sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;
  logic       fall_q;

  // prev_q is the synchronized level aligned with the edge pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= ~sync_q[1] & prev_q;
    end
  end

  assign s_o    = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// rtl/anton_neopixel_decoder.sv - WS2812 line decoder into a byte capture buffer
// Optional glitch counter on errCount: ANTON_NEOPIXEL_DECODER_STATS_EN
module anton_neopixel_decoder
  import anton_neopixel_decoder_pkg::*;
#(
  parameter  int BUFFER_END  = 31,
  parameter  int RESET_TICKS = 280,
  parameter  int ONE_MIN     = 4,
  localparam int AW          = clog2(BUFFER_END + 1)
) (
  input  logic          clk7mhz,
  input  logic          rstn,
  input  logic          neoData,
  output logic          byteValid,
  output logic [AW-1:0] byteAddr,
  output logic [7:0]    byteData,
  output logic          frameDone,
  output logic [AW:0]   frameBytes,
  output logic          errGlitch,
  output logic          errOverflow,
  output logic          errPartial,
  input  logic          errClear,
  output logic [7:0]    errCount
);

  localparam logic [9:0] LO_END    = 10'(RESET_TICKS - 1);
  localparam logic [3:0] HI_GLITCH = 4'(BIT_TICKS);
  localparam logic [3:0] ONE_THR   = 4'(ONE_MIN);
  localparam logic [AW:0] ADDR_LAST = (AW+1)'(BUFFER_END);

  logic s, rise, fall;

  anton_sync_edge u_sync_edge (
    .clk_i  (clk7mhz),
    .rstn_i (rstn),
    .d_i    (neoData),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  dec_state_e  state_q;
  logic [3:0]  hi_cnt_q;
  logic [9:0]  lo_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [AW:0] addr_q;
  logic        byte_valid_q, frame_done_q;
  logic [AW-1:0] byte_addr_q;
  logic [7:0]  byte_data_q;
  logic [AW:0] frame_bytes_q;
  logic        err_glitch_q, err_overflow_q, err_partial_q;

  logic       glitch_evt;
  logic       bit_val;
  logic [7:0] next_byte;

  // A still-high pulse at BIT_TICKS is already too wide, so it aborts without waiting for the fall.
  assign glitch_evt = (state_q == ENUM_DEC_HIGH) &&
                      ((hi_cnt_q >= HI_GLITCH) || (fall && hi_cnt_q == 4'd0));
  assign bit_val    = (hi_cnt_q >= ONE_THR);
  assign next_byte  = {shift_q[6:0], bit_val};

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ENUM_DEC_SYNC;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      addr_q         <= '0;
      byte_valid_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      byte_addr_q    <= '0;
      byte_data_q    <= '0;
      frame_bytes_q  <= '0;
      err_glitch_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      err_partial_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (errClear) begin
        err_glitch_q   <= 1'b0;
        err_overflow_q <= 1'b0;
        err_partial_q  <= 1'b0;
      end
      case (state_q)
        ENUM_DEC_SYNC: begin
          if (s) begin
            lo_cnt_q <= '0;
          end else if (lo_cnt_q >= LO_END) begin
            lo_cnt_q <= '0;
            state_q  <= ENUM_DEC_IDLE;
          end else begin
            lo_cnt_q <= lo_cnt_q + 10'd1;
          end
        end
        ENUM_DEC_IDLE: begin
          if (rise) begin
            hi_cnt_q <= 4'd1;
            state_q  <= ENUM_DEC_HIGH;
          end
        end
        ENUM_DEC_HIGH: begin
          if (glitch_evt) begin
            err_glitch_q <= 1'b1;
            bit_cnt_q    <= '0;
            lo_cnt_q     <= '0;
            state_q      <= ENUM_DEC_SYNC;
          end else if (fall) begin
            shift_q  <= next_byte;
            lo_cnt_q <= 10'd1;
            state_q  <= ENUM_DEC_LOW;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              if (addr_q <= ADDR_LAST) begin
                byte_valid_q <= 1'b1;
                byte_addr_q  <= addr_q[AW-1:0];
                byte_data_q  <= next_byte;
                addr_q       <= addr_q + 1'b1;
              end else begin
                err_overflow_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (hi_cnt_q != 4'hF) begin
            hi_cnt_q <= hi_cnt_q + 4'd1;
          end
        end
        ENUM_DEC_LOW: begin
          if (rise) begin
            hi_cnt_q <= 4'd1;
            state_q  <= ENUM_DEC_HIGH;
          end else if (lo_cnt_q >= LO_END) begin
            frame_done_q  <= 1'b1;
            frame_bytes_q <= addr_q;
            if (bit_cnt_q != 4'd0) err_partial_q <= 1'b1;
            addr_q    <= '0;
            bit_cnt_q <= '0;
            state_q   <= ENUM_DEC_IDLE;
          end else if (lo_cnt_q != 10'h3FF) begin
            lo_cnt_q <= lo_cnt_q + 10'd1;
          end
        end
        default: state_q <= ENUM_DEC_SYNC;
      endcase
    end
  end

`ifdef ANTON_NEOPIXEL_DECODER_STATS_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      err_count_q <= '0;
    end else if (errClear) begin
      err_count_q <= glitch_evt ? 8'd1 : 8'd0;
    end else if (glitch_evt && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign errCount = err_count_q;
`else
  assign errCount = 8'd0;
`endif

  assign byteValid   = byte_valid_q;
  assign byteAddr    = byte_addr_q;
  assign byteData    = byte_data_q;
  assign frameDone   = frame_done_q;
  assign frameBytes  = frame_bytes_q;
  assign errGlitch   = err_glitch_q;
  assign errOverflow = err_overflow_q;
  assign errPartial  = err_partial_q;

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// tb/tb_anton_neopixel_decoder.sv - randomized frame bench against a byte-level reference model
module tb_anton_neopixel_decoder;

  localparam int BE = 3;
  localparam int RT = 280;
  localparam int OM = 4;
  localparam int AW = 2;

  logic          clk7mhz = 1'b0;
  logic          rstn;
  logic          neoData;
  logic          byteValid;
  logic [AW-1:0] byteAddr;
  logic [7:0]    byteData;
  logic          frameDone;
  logic [AW:0]   frameBytes;
  logic          errGlitch, errOverflow, errPartial;
  logic          errClear;
  logic [7:0]    errCount;

  anton_neopixel_decoder #(.BUFFER_END(BE), .RESET_TICKS(RT), .ONE_MIN(OM)) dut (
    .clk7mhz    (clk7mhz),
    .rstn       (rstn),
    .neoData    (neoData),
    .byteValid  (byteValid),
    .byteAddr   (byteAddr),
    .byteData   (byteData),
    .frameDone  (frameDone),
    .frameBytes (frameBytes),
    .errGlitch  (errGlitch),
    .errOverflow(errOverflow),
    .errPartial (errPartial),
    .errClear   (errClear),
    .errCount   (errCount)
  );

  always #5 clk7mhz = ~clk7mhz;

  int n_chk = 0;
  int n_fail = 0;

  int got_addr[$];
  int got_data[$];
  int frame_cnt = 0;
  int last_frame_bytes = 0;

  bit tx_bits[$];
  int tx_hi[$];

  always @(negedge clk7mhz) begin
    if (byteValid) begin
      got_addr.push_back(int'(byteAddr));
      got_data.push_back(int'(byteData));
    end
    if (frameDone) begin
      frame_cnt++;
      last_frame_bytes = int'(frameBytes);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk7mhz);
  endtask

  // mode 0: nominal 2H/5H, mode 1: random legal widths, mode 2: threshold widths 3H/4H
  task automatic push_byte(input logic [7:0] b, input int mode);
    for (int i = 7; i >= 0; i--) begin
      tx_bits.push_back(b[i]);
      case (mode)
        0: tx_hi.push_back(b[i] ? 5 : 2);
        2: tx_hi.push_back(b[i] ? OM : OM - 1);
        default: tx_hi.push_back(b[i] ? int'($urandom_range(7, OM)) : int'($urandom_range(OM - 1, 1)));
      endcase
    end
  endtask

  task automatic send_bits();
    for (int i = 0; i < tx_bits.size(); i++) begin
      neoData = 1'b1;
      tick(tx_hi[i]);
      neoData = 1'b0;
      tick(8 - tx_hi[i]);
    end
  endtask

  task automatic clear_errors();
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
    tick(1);
    chk("clr_glitch", errGlitch, 0);
    chk("clr_overflow", errOverflow, 0);
    chk("clr_partial", errPartial, 0);
    chk("clr_count", errCount, 0);
  endtask

  task automatic run_frame();
    int fc0, n, nbytes, stored;
    logic [7:0] exp_b;
    fc0 = frame_cnt;
    got_addr.delete();
    got_data.delete();
    send_bits();
    n = 0;
    while (frame_cnt == fc0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("frame_done_seen", frame_cnt, fc0 + 1);
    nbytes = tx_bits.size() / 8;
    stored = (nbytes > BE + 1) ? BE + 1 : nbytes;
    chk("strobe_count", got_addr.size(), stored);
    for (int k = 0; k < stored && k < got_addr.size(); k++) begin
      exp_b = 8'h00;
      for (int j = 0; j < 8; j++) exp_b = {exp_b[6:0], tx_bits[8*k + j]};
      chk("byte_addr", got_addr[k], k);
      chk("byte_data", got_data[k], exp_b);
    end
    chk("frame_bytes", last_frame_bytes, stored);
    chk("err_overflow", errOverflow, nbytes > BE + 1);
    chk("err_partial", errPartial, (tx_bits.size() % 8) != 0);
    chk("err_glitch", errGlitch, 0);
    tx_bits.delete();
    tx_hi.delete();
    clear_errors();
  endtask

  initial begin
    int fc0, nb, extra;
    rstn = 1'b0;
    neoData = 1'b0;
    errClear = 1'b0;
    tick(3);
    chk("rst_valid", byteValid, 0);
    chk("rst_addr", byteAddr, 0);
    chk("rst_data", byteData, 0);
    chk("rst_done", frameDone, 0);
    chk("rst_fbytes", frameBytes, 0);
    chk("rst_flags", {errGlitch, errOverflow, errPartial}, 0);
    chk("rst_count", errCount, 0);

    // Line already carrying data when reset releases: must stay gated.
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      neoData = 1'b1; tick(5);
      neoData = 1'b0; tick(3);
    end
    chk("sync_gate_no_bytes", got_addr.size(), 0);
    tick(300);
    chk("sync_no_frame_done", frame_cnt, 0);
    chk("sync_no_glitch", errGlitch, 0);

    push_byte(8'hA5, 0); push_byte(8'h3C, 0); push_byte(8'hFF, 0);
    run_frame();

    push_byte(8'h5A, 2); push_byte(8'hC3, 2);
    run_frame();

    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0);
    push_byte(8'h44, 0); push_byte(8'h55, 0);
    run_frame();

    push_byte(8'h9E, 0);
    for (int i = 0; i < 4; i++) tx_bits.push_back(1'b1);
    for (int i = 0; i < 4; i++) tx_hi.push_back(5);
    run_frame();

    for (int f = 0; f < 8; f++) begin
      nb = $urandom_range(6, 1);
      extra = ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 1)) : 0;
      for (int i = 0; i < nb; i++) push_byte(8'($urandom), 1);
      for (int i = 0; i < extra; i++) begin
        tx_bits.push_back(1'b0);
        tx_hi.push_back(2);
      end
      run_frame();
    end

    // Over-wide pulse: glitch, back to SYNC, no frame end on resync.
    fc0 = frame_cnt;
    neoData = 1'b1; tick(9);
    neoData = 1'b0; tick(20);
    chk("glitch_flag", errGlitch, 1);
`ifdef ANTON_NEOPIXEL_DECODER_STATS_EN
    chk("glitch_count", errCount, 1);
`else
    chk("glitch_count", errCount, 0);
`endif
    tick(300);
    chk("glitch_no_frame_done", frame_cnt, fc0);
    clear_errors();
    push_byte(8'h6B, 0);
    run_frame();

    // Reset mid-frame.
    push_byte(8'hF0, 0);
    tx_bits.push_back(1'b1); tx_hi.push_back(5);
    tx_bits.push_back(1'b0); tx_hi.push_back(2);
    send_bits();
    tx_bits.delete();
    tx_hi.delete();
    rstn = 1'b0;
    #1;
    chk("midrst_valid", byteValid, 0);
    chk("midrst_addr", byteAddr, 0);
    chk("midrst_data", byteData, 0);
    chk("midrst_fbytes", frameBytes, 0);
    chk("midrst_flags", {errGlitch, errOverflow, errPartial, frameDone}, 0);
    tick(2);
    rstn = 1'b1;
    tick(300);
    push_byte(8'h81, 1); push_byte(8'h7E, 1);
    run_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
